// File: rtl/addr_step_counter.sv
// Loadable up/down address counter with AND-OR load mux, carry pulse and programmable terminal count.
// Optional macro COUNTER_WRAP_EN: a step at terminal count reloads the loaded base (wrap mode) instead of holding.
module addr_step_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             MasterClock,
  input  logic             reset,
  input  logic             lda,
  input  logic [WIDTH-1:0] da,
  input  logic             ldb,
  input  logic [WIDTH-1:0] db,
  input  logic             step,
  input  logic             down,
  input  logic             lim_ld,
  input  logic [WIDTH-1:0] lim_d,
  output logic [WIDTH-1:0] q,
  output logic             carry,
  output logic             term
);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             term_q, term_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] load_val_c;
  logic [WIDTH-1:0] step_val_c;
  logic             load_c;
`ifdef COUNTER_WRAP_EN
  logic [WIDTH-1:0] base_q, base_d;
`endif

  // Two-source AND-OR load mux; both strobes high simply OR the sources.
  always_comb begin
    load_val_c = ({WIDTH{lda}} & da) | ({WIDTH{ldb}} & db);
    load_c     = lda | ldb;
    step_val_c = down ? (count_q - WIDTH'(1)) : (count_q + WIDTH'(1));
  end

  always_comb begin
    count_d = count_q;
    limit_d = lim_ld ? lim_d : limit_q;
    term_d  = term_q;
    carry_d = 1'b0;
`ifdef COUNTER_WRAP_EN
    base_d  = base_q;
`endif
    if (load_c) begin
      count_d = load_val_c;
      term_d  = 1'b0;
`ifdef COUNTER_WRAP_EN
      base_d  = load_val_c;
`endif
    end else if (step && !term_q) begin
      count_d = step_val_c;
      carry_d = down ? (count_q == '0) : (count_q == '1);
      // Compared against the limit currently held, even if it is being rewritten this cycle.
      term_d  = (step_val_c == limit_q);
    end else if (step) begin
`ifdef COUNTER_WRAP_EN
      count_d = base_q;
      term_d  = 1'b0;
`endif
    end
  end

  always_ff @(posedge MasterClock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      limit_q <= '1;
      term_q  <= 1'b0;
      carry_q <= 1'b0;
`ifdef COUNTER_WRAP_EN
      base_q  <= '0;
`endif
    end else begin
      count_q <= count_d;
      limit_q <= limit_d;
      term_q  <= term_d;
      carry_q <= carry_d;
`ifdef COUNTER_WRAP_EN
      base_q  <= base_d;
`endif
    end
  end

  assign q     = count_q;
  assign carry = carry_q;
  assign term  = term_q;

endmodule

// File: tb/tb_addr_step_counter.sv
// Self-checking bench for addr_step_counter: behavioural model feeds a scoreboard of expected {q,carry,term}.
module tb_addr_step_counter;

  logic        clk, rst;
  logic        lda, ldb, step, down, lim_ld;
  logic [15:0] da, db, lim_d;
  logic [15:0] q;
  logic        carry, term;

  int checks = 0;
  int errors = 0;

  logic [17:0] sb[$];
  logic [15:0] m_q, m_base, m_lim;
  logic        m_term;

  addr_step_counter #(.WIDTH(16)) dut (
    .MasterClock(clk), .reset(rst),
    .lda(lda), .da(da), .ldb(ldb), .db(db),
    .step(step), .down(down),
    .lim_ld(lim_ld), .lim_d(lim_d),
    .q(q), .carry(carry), .term(term)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_q = 16'h0; m_base = 16'h0; m_lim = 16'hFFFF; m_term = 1'b0;
    sb.delete();
  endtask

  // Drive one cycle of stimulus, predict the post-edge outputs, then step past the edge.
  task automatic drive(input logic a, input logic [15:0] va, input logic b, input logic [15:0] vb,
                       input logic s, input logic dn, input logic ll, input logic [15:0] lv);
    logic [15:0] lval, nq;
    logic        nc, nt;
    lda = a; da = va; ldb = b; db = vb; step = s; down = dn; lim_ld = ll; lim_d = lv;
    lval = (a ? va : 16'h0) | (b ? vb : 16'h0);
    nq = m_q; nc = 1'b0; nt = m_term;
    if (a || b) begin
      nq = lval; m_base = lval; nt = 1'b0;
    end else if (s && !m_term) begin
      nq = dn ? m_q - 16'd1 : m_q + 16'd1;
      nc = dn ? (m_q == 16'h0000) : (m_q == 16'hFFFF);
      nt = (nq == m_lim);
    end else if (s) begin
`ifdef COUNTER_WRAP_EN
      nq = m_base; nt = 1'b0;
`endif
    end
    if (ll) m_lim = lv;
    m_q = nq; m_term = nt;
    sb.push_back({nq, nc, nt});
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(0, 16'h0, 0, 16'h0, 0, 0, 0, 16'h0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    lda = 0; ldb = 0; da = 0; db = 0; step = 0; down = 0; lim_ld = 0; lim_d = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({q, carry, term} !== 18'h0) begin
      errors++;
      $display("FAIL reset: got q=%h c=%b t=%b, exp q=0000 c=0 t=0", q, carry, term);
    end
    #3 rst = 1'b0;
  endtask

  task automatic test_count_up();
    logic [17:0] exp;
    drive(1, 16'h00FE, 0, 16'h0, 0, 0, 0, 16'h0);
    for (int i = 0; i < 4; i++) begin
      exp = sb.pop_front();
      checks++;
      if ({q, carry, term} !== exp) begin
        errors++;
        $display("FAIL count_up[%0d]: got q=%h c=%b t=%b, exp q=%h c=%b t=%b", i, q, carry, term, exp[17:2], exp[1], exp[0]);
      end
      if (i < 3) drive(0, 16'h0, 0, 16'h0, 1, 0, 0, 16'h0);
    end
  endtask

  task automatic test_carry();
    logic [17:0] exp;
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: drive(1, 16'hFFFF, 0, 16'h0, 0, 0, 0, 16'h0);
        1: drive(0, 16'h0, 0, 16'h0, 1, 0, 0, 16'h0);
        2: idle();
        3: drive(0, 16'h0, 1, 16'h0000, 0, 0, 0, 16'h0);
        4: drive(0, 16'h0, 0, 16'h0, 1, 1, 0, 16'h0);
        default: idle();
      endcase
      exp = sb.pop_front();
      checks++;
      if ({q, carry, term} !== exp) begin
        errors++;
        $display("FAIL carry[%0d]: got q=%h c=%b t=%b, exp q=%h c=%b t=%b", i, q, carry, term, exp[17:2], exp[1], exp[0]);
      end
    end
  endtask

  task automatic test_term();
    logic [17:0] exp;
    for (int i = 0; i < 9; i++) begin
      case (i)
        0: drive(0, 16'h0, 0, 16'h0, 0, 0, 1, 16'h0010);
        1: drive(1, 16'h0010, 0, 16'h0, 0, 0, 0, 16'h0);
        2: drive(1, 16'h000E, 0, 16'h0, 0, 0, 0, 16'h0);
        default: drive(0, 16'h0, 0, 16'h0, 1, 0, 0, 16'h0);
      endcase
      exp = sb.pop_front();
      checks++;
      if ({q, carry, term} !== exp) begin
        errors++;
        $display("FAIL term[%0d]: got q=%h c=%b t=%b, exp q=%h c=%b t=%b", i, q, carry, term, exp[17:2], exp[1], exp[0]);
      end
    end
  endtask

  task automatic test_dual_load();
    logic [17:0] exp;
    drive(1, 16'h0F0F, 1, 16'h30F0, 1, 0, 0, 16'h0);
    exp = sb.pop_front();
    checks++;
    if ({q, carry, term} !== exp || q !== 16'h3FFF) begin
      errors++;
      $display("FAIL dual_load: got q=%h c=%b t=%b, exp q=%h c=%b t=%b", q, carry, term, exp[17:2], exp[1], exp[0]);
    end
  endtask

  task automatic test_limit_same_cycle();
    logic [17:0] exp;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: drive(1, 16'h0004, 0, 16'h0, 0, 0, 1, 16'hFFFF);
        1: drive(0, 16'h0, 0, 16'h0, 1, 0, 1, 16'h0005);
        default: drive(0, 16'h0, 0, 16'h0, 1, 0, 0, 16'h0);
      endcase
      exp = sb.pop_front();
      checks++;
      if ({q, carry, term} !== exp) begin
        errors++;
        $display("FAIL limit_same_cycle[%0d]: got q=%h c=%b t=%b, exp q=%h c=%b t=%b", i, q, carry, term, exp[17:2], exp[1], exp[0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [17:0] exp;
    for (int i = 0; i < 80; i++) begin
      drive(($urandom % 8) == 0, 16'($urandom), ($urandom % 10) == 0, 16'($urandom),
            ($urandom % 4) != 0, ($urandom % 5) == 0,
            ($urandom % 6) == 0, m_q + 16'($urandom_range(1, 4)));
      exp = sb.pop_front();
      checks++;
      if ({q, carry, term} !== exp) begin
        errors++;
        $display("FAIL back_to_back[%0d]: got q=%h c=%b t=%b, exp q=%h c=%b t=%b", i, q, carry, term, exp[17:2], exp[1], exp[0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [17:0] exp;
    drive(1, 16'h1230, 0, 16'h0, 0, 0, 1, 16'hFFFF);
    exp = sb.pop_front();
    for (int i = 0; i < 4; i++) begin
      drive(0, 16'h0, 0, 16'h0, 1, 0, 0, 16'h0);
      exp = sb.pop_front();
    end
    checks++;
    if ({q, carry, term} !== exp || q !== 16'h1234) begin
      errors++;
      $display("FAIL reset_mid_pre: got q=%h, exp q=1234", q);
    end
    #2 rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if ({q, carry, term} !== 18'h0) begin
      errors++;
      $display("FAIL reset_mid_async: got q=%h c=%b t=%b, exp q=0000 c=0 t=0", q, carry, term);
    end
    #2 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(0, 16'h0, 0, 16'h0, 1, 0, 0, 16'h0);
      exp = sb.pop_front();
      checks++;
      if ({q, carry, term} !== exp || q !== 16'(i + 1)) begin
        errors++;
        $display("FAIL reset_mid_count[%0d]: got q=%h c=%b t=%b, exp q=%h c=%b t=%b", i, q, carry, term, exp[17:2], exp[1], exp[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_carry();
    test_term();
    test_dual_load();
    test_limit_same_cycle();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
